// File: rtl/jtdd_layermix_if.sv
// CPU palette port of jtdd_layermix: address, write data, strobes and read-back byte.
interface jtdd_layermix_if #(
  parameter int PALW = 9
);
  // A bus cycle is any clk with pal_cs & cen_E high; cpu_wrn low makes it a write that
  // lands on that clk. There are no wait states: read data is on pal_dout one clk later.
  logic [PALW:0] cpu_AB;
  logic [7:0]    cpu_dout;
  logic          cpu_wrn;
  logic          cen_E;
  logic          pal_cs;
  logic [7:0]    pal_dout;

  modport master (
    output cpu_AB, cpu_dout, cpu_wrn, cen_E, pal_cs,
    input  pal_dout
  );

  modport slave (
    input  cpu_AB, cpu_dout, cpu_wrn, cen_E, pal_cs,
    output pal_dout
  );
endinterface

// File: rtl/jtdd_layermix.sv
// Layer mixer: picks the winning layer pixel by priority PROM (or fixed order), looks it up
// in a CPU-writable 12-bit palette and emits blanked RGB four pixel ticks after sampling.
module jtdd_layermix #(
  parameter int LAYERS     = 3,
  parameter int PXLW       = 7,
  parameter int FIXED_PRIO = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pxl_cen,
  input  logic [LAYERS*PXLW-1:0]   layer_pxl,
  input  logic [1:0]               prio_sel,
  input  logic                     LHBL,
  input  logic                     LVBL,
  jtdd_layermix_if.slave           cpu,
  input  logic [7:0]               prog_addr,
  input  logic [3:0]               prom_din,
  input  logic                     prom_prio_we,
  output logic                     LHBL_dly,
  output logic                     LVBL_dly,
  output logic [3:0]               red,
  output logic [3:0]               green,
  output logic [3:0]               blue
);
  localparam int PALW = PXLW + 2;
  localparam int PALN = 1 << PALW;

  // Palette kept as two arrays so a byte write touches only its own half of the entry.
  logic [7:0] pal_gr_mem [PALN];
  logic [3:0] pal_b_mem  [PALN];
  logic [1:0] prom_mem   [256];

  logic            cpu_acc;
  logic            cpu_we;
  logic            cpu_hi;
  logic [PALW-1:0] cpu_idx;

  assign cpu_acc = cpu.pal_cs & cpu.cen_E;
  assign cpu_we  = cpu_acc & ~cpu.cpu_wrn;
  assign cpu_hi  = cpu.cpu_AB[PALW];
  assign cpu_idx = cpu.cpu_AB[PALW-1:0];

  always_ff @(posedge clk) begin
    if (cpu_we) begin
      if (cpu_hi) pal_b_mem[cpu_idx] <= cpu.cpu_dout[3:0];
      else        pal_gr_mem[cpu_idx] <= cpu.cpu_dout;
    end
  end

  // Only the two low PROM bits ever select a winner, so the upper pair is not stored.
  always_ff @(posedge clk) begin
    if (prom_prio_we) prom_mem[prog_addr] <= prom_din[1:0];
  end

  logic unused_prom_hi;
  assign unused_prom_hi = ^prom_din[3:2];

  logic [7:0] pal_dout_q, pal_dout_d;

  always_comb begin
    pal_dout_d = pal_dout_q;
    if (cpu_acc) pal_dout_d = cpu_hi ? {4'd0, pal_b_mem[cpu_idx]} : pal_gr_mem[cpu_idx];
  end

  always_ff @(posedge clk) begin
    if (!rst) pal_dout_q <= '0;
    else      pal_dout_q <= pal_dout_d;
  end

  assign cpu.pal_dout = pal_dout_q;

  logic [LAYERS-1:0]      opaque_d;
  logic [LAYERS*PXLW-1:0] pxl1_q;
  logic [LAYERS-1:0]      opaque1_q;
  logic [1:0]             prio1_q;

  always_comb begin
    opaque_d = '0;
    for (int k = 0; k < LAYERS; k++) opaque_d[k] = |layer_pxl[k*PXLW +: 4];
  end

  logic [5:0]      opq6;
  logic [7:0]      prom_addr;
  logic [1:0]      prom_w, win_prom, win_fix, win_d;
  logic [PXLW-1:0] pix_d;
  logic [PALW-1:0] addr2_q;

  // A PROM winner naming a layer that does not exist falls back to layer 0.
  always_comb begin
    opq6 = '0;
    opq6[LAYERS-1:0] = opaque1_q;
    prom_addr = {prio1_q, opq6};
    prom_w    = prom_mem[prom_addr];
    win_prom  = (int'(prom_w) >= LAYERS) ? 2'd0 : prom_w;
    win_fix   = 2'd0;
    for (int k = 0; k < LAYERS; k++) begin
      if (opaque1_q[k]) win_fix = 2'(k);
    end
    win_d = (FIXED_PRIO != 0) ? win_fix : win_prom;
    pix_d = '0;
    for (int k = 0; k < LAYERS; k++) begin
      if (win_d == 2'(k)) pix_d = pxl1_q[k*PXLW +: PXLW];
    end
  end

  logic [11:0] ent3_q;
  logic [3:0]  hb_sr_q, vb_sr_q;
  logic [3:0]  red_q, green_q, blue_q;
  logic        show3;

  assign show3 = hb_sr_q[2] & vb_sr_q[2];

  // Stage 3 reads the palette with the pre-edge contents, so a same-clk CPU write is
  // seen by video only from the following clk.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pxl1_q    <= '0;
      opaque1_q <= '0;
      prio1_q   <= '0;
      addr2_q   <= '0;
      ent3_q    <= '0;
      hb_sr_q   <= '0;
      vb_sr_q   <= '0;
      red_q     <= '0;
      green_q   <= '0;
      blue_q    <= '0;
    end else if (pxl_cen) begin
      pxl1_q    <= layer_pxl;
      opaque1_q <= opaque_d;
      prio1_q   <= prio_sel;
      addr2_q   <= {win_d, pix_d};
      ent3_q    <= {pal_b_mem[addr2_q], pal_gr_mem[addr2_q]};
      hb_sr_q   <= {hb_sr_q[2:0], LHBL};
      vb_sr_q   <= {vb_sr_q[2:0], LVBL};
      red_q     <= show3 ? ent3_q[3:0]  : 4'd0;
      green_q   <= show3 ? ent3_q[7:4]  : 4'd0;
      blue_q    <= show3 ? ent3_q[11:8] : 4'd0;
    end
  end

  assign LHBL_dly = hb_sr_q[3];
  assign LVBL_dly = vb_sr_q[3];
  assign red      = red_q;
  assign green    = green_q;
  assign blue     = blue_q;
endmodule

// File: doc/jtdd_layermix.md
JTDD_LAYERMIX -- requirements
Module: jtdd_layermix

Interface
REQ-001 Parameter LAYERS, default 3: number of tile/sprite layers mixed, legal range 2..4.
REQ-002 Parameter PXLW, default 7: bits per layer pixel; bits [3:0] are colour index, upper bits are palette bank.
REQ-003 Parameter FIXED_PRIO, default 0: 1 bypasses the priority PROM and uses fixed priority.
REQ-004 Derived PALW = PXLW+2: palette address width.
REQ-005 Clock and reset: one clock; reset is synchronous and active-low.
REQ-006 clk  in  1  system clock.
REQ-007 rst  in  1  synchronous reset, active-low.
REQ-008 pxl_cen  in  1  pixel clock enable.
REQ-009 layer_pxl  in  LAYERS*PXLW  packed pixels; layer k occupies [k*PXLW +: PXLW].
REQ-010 prio_sel  in  2  game-controlled priority mode.
REQ-011 LHBL, LVBL  in  1 each  active-low blanking.
REQ-012 cpu_AB  in  PALW+1  palette byte address.
REQ-013 cpu_dout  in  8  CPU write data.
REQ-014 cpu_wrn  in  1  CPU write, active-low.
REQ-015 cen_E  in  1  CPU bus enable.
REQ-016 pal_cs  in  1  palette chip select.
REQ-017 pal_dout  out  8  palette read data.
REQ-018 prog_addr  in  8  PROM address; prom_din  in  4  PROM data; prom_prio_we  in  1  PROM write.
REQ-019 LHBL_dly, LVBL_dly  out  1 each  blanking aligned to colour output.
REQ-020 red, green, blue  out  4 each  pixel colour.

Function
REQ-021 Layer k is opaque iff layer_pxl bits [k*PXLW +: 4] are nonzero.
REQ-022 Stage 1, on pxl_cen: register all layer pixels, opaque vector, prio_sel, LHBL, LVBL.
REQ-023 Stage 2, on pxl_cen: winner index = PROM[{prio_sel, opaque zero-extended to 6 bits}][1:0] when FIXED_PRIO=0; PROM bits [3:2] ignored.
REQ-024 FIXED_PRIO=1: winner = highest-numbered opaque layer; 0 when no layer is opaque.
REQ-025 A winner index >= LAYERS from the PROM SHALL be forced to 0.
REQ-026 Stage 3, on pxl_cen: palette address = {winner[1:0], winner pixel[PXLW-1:0]}; palette entry 12 bits {B,G,R}.
REQ-027 Stage 4, on pxl_cen: red/green/blue registered from palette entry; forced to 0 when delayed LHBL or LVBL is low.
REQ-028 Total latency: 4 pxl_cen ticks from layer_pxl sample to colour output; LHBL_dly/LVBL_dly delayed exactly 4 ticks.
REQ-029 With pxl_cen low, all pipeline registers and outputs hold.
REQ-030 Palette CPU map: cpu_AB[PALW]=0 selects byte {G,R}; cpu_AB[PALW]=1 selects {4'b0,B}; cpu_AB[PALW-1:0] selects entry.
REQ-031 CPU write occurs when pal_cs & ~cpu_wrn & cen_E; one write per qualifying clock; blue writes take cpu_dout[3:0].
REQ-032 pal_dout is registered and updates one clk after pal_cs & cen_E with the addressed byte; upper nibble of blue byte reads 0.
REQ-033 Palette is dual-port: a video read and CPU write to the same entry in one clk SHALL return old data to video, new data from next clk.
REQ-034 PROM write: prom_prio_we high writes prom_din to PROM[prog_addr] on that clk, independent of pxl_cen.
REQ-035 CPU writes and PROM writes SHALL never stall the video pipeline.

Reset
REQ-036 While rst low: red, green, blue = 0; LHBL_dly, LVBL_dly = 0; pal_dout = 0; all pipeline stages cleared.
REQ-037 Palette RAM and PROM contents are not altered by reset.
REQ-038 Reset mid-frame: outputs 0 on the clk after rst sampled low; after release, first valid colour 4 pxl_cen ticks later.

Verification
REQ-039 FIXED_PRIO=1, LAYERS=3, layer0=0x05, layer1=0x00, layer2=0x13, blanking high, palette[0x113]=0xABC -> after 4 pxl_cen: red=0xC, green=0xB, blue=0xA.
REQ-040 FIXED_PRIO=0, PROM[{2'd1,6'b000011}]=4'h0, prio_sel=1, layer0=0x02, layer1=0x07 -> palette[0x002] shown; PROM entry 4'h3 with LAYERS=3 -> palette[0x002] also shown.
REQ-041 CPU writes 0x5A to AB=0x010, 0x07 to AB=0x210 (PALW=9), reads both -> pal_dout 0x5A then 0x07; video for entry 0x010 gives R=0xA, G=0x5, B=0x7.
REQ-042 LHBL low for one pixel with valid opaque input -> red/green/blue=0 and LHBL_dly low exactly 4 pxl_cen later, for one pixel.
REQ-043 Same-clk CPU write and video read of entry 0x020 -> that pixel shows old colour; next pixel on 0x020 shows new.
REQ-044 rst low mid-line with opaque pixels streaming -> all outputs 0 next clk; palette content unchanged after release.
